frame_strobe_sequencer: RTL and testbench
=========================================

Name: frame_strobe_sequencer

Overview:
- Configuration-frame controller for a fabric column set built from terminal and RAM-IO tiles.
- Accepts a word stream of frame packets, assembles one frame's FrameData across all rows, then pulses exactly one FrameStrobe bit for the addressed column and frame index.
- Sits between the bitstream source (UART/SPI config port) and the per-column FrameStrobe/FrameData chains that each tile buffers and forwards northward.

Parameters:
- MaxFramesPerCol, 20, frames per column; width of one column's strobe slice.
- FrameBitsPerRow, 32, config bits per row per frame; equals the stream word width.
- NumRows, 4, tile rows covered by one frame.
- NumColumns, 4, columns addressable.
- StrobeCycles, 2, FrameStrobe high time in clocks (>=1).

Ports:
- UserCLK  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_data  in  FrameBitsPerRow  stream word (header, data or checksum)
- in_valid  in  1  word valid
- in_ready  out  1  word accepted when in_valid&in_ready at rising UserCLK
- FrameData  out  FrameBitsPerRow*NumRows  assembled frame; row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow]
- FrameStrobe  out  MaxFramesPerCol*NumColumns  one-hot strobe; column c, frame f at bit c*MaxFramesPerCol+f
- busy  out  1  high in any state except IDLE
- err  out  1  sticky packet error
- err_clr  in  1  synchronous clear of err
- frames_done  out  16  count of frames strobed, wraps at 0xFFFF->0

Behaviour:
- Interface: one clock, UserCLK; reset resetn is asynchronous, active-low.
- Reset values: FrameData=0, FrameStrobe=0, in_ready=0 during reset, busy=0, err=0, frames_done=0, state IDLE. Reset asserted mid-packet aborts the packet with no strobe; the next packet starts from a header.
- Header word: [31:24]=8'hFA sync, [15:8]=column, [4:0]=frame index; other bits ignored.
- States: IDLE -> LOAD -> (CHECK if FRAME_CRC_EN) -> STROBE -> GAP -> IDLE.
- IDLE: in_ready=1. On accepted header:
  - Latch col/frame and clear row counter.
  - Bad sync: word discarded, err set, stay IDLE.
  - Valid sync: go to LOAD. Set an internal drop flag if col>=NumColumns or frame>=MaxFramesPerCol.
- LOAD: in_ready=1.
  - Accepted word k (k=0..NumRows-1) is written to row k of FrameData at that edge, only when drop flag=0.
  - After word NumRows-1: go to STROBE, or to CHECK if FRAME_CRC_EN.
  - If drop flag=1: FrameData is untouched, err is set on the final word, and the next state is GAP (no strobe).
- in_valid low stalls any state that waits for data; no timeout.
- STROBE: in_ready=0.
  - FrameStrobe bit is high for exactly StrobeCycles clocks, starting the cycle after the last data (or checksum) word is accepted.
  - frames_done increments on entry.
  - FrameData is stable throughout STROBE and GAP.
- GAP: one cycle, FrameStrobe=0, in_ready=0, then IDLE. Guarantees a low strobe between back-to-back frames.
- FrameData holds its value until overwritten by the next valid packet.
- err_clr and an error-setting event in the same cycle: err stays 1.
- in_data is ignored when in_valid=0. Outputs are never glitched combinationally; FrameStrobe comes from flops.

Optional Feature:
- Macro: FRAME_CRC_EN.
- Defined:
  - LOAD keeps a running XOR of the NumRows data words.
  - CHECK (in_ready=1) accepts one extra checksum word.
  - Match: go to STROBE.
  - Mismatch: set err, skip strobe, go to GAP, FrameData keeps the loaded (unstrobed) contents.
  - Dropped packets still consume the checksum word.
- Not defined: no CHECK state; packet is header plus NumRows words.

Test Plan:
- Reset, then header 32'hFA00_0103 (col 1, frame 3) and words 11111111, 22222222, 33333333, 44444444 with in_valid held high:
  - FrameData = 44444444_33333333_22222222_11111111.
  - FrameStrobe bit 23 high for 2 cycles starting one cycle after the 4th word.
  - frames_done = 1; in_ready low for 3 cycles.
- Header 32'hFA00_0500 (col 5 >= NumColumns) plus 4 words:
  - FrameStrobe stays 0, FrameData unchanged, err=1.
  - err_clr pulse returns err to 0.
- Header 32'h1200_0000 (bad sync): err=1, state IDLE. A following valid packet for col 0, frame 0 strobes bit 0.
- Back-to-back packets for frames 19 and 0 of col 3 (bits 79 and 60):
  - Each pulse lasts 2 cycles.
  - At least one zero cycle separates them; frames_done = 2.
- resetn low after 2 data words, then a full packet:
  - No strobe is produced from the aborted packet.
  - The new packet strobes correctly; frames_done = 1.
- FRAME_CRC_EN, words 1, 2, 4, 8:
  - Checksum 0000000F strobes.
  - Checksum 0000000E gives no strobe and err=1.

Source files
------------

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: assembles one configuration frame from a word stream
// (header, NumRows data words, optional checksum word) into FrameData, then
// pulses the addressed FrameStrobe bit for StrobeCycles clocks.
// Build option: define FRAME_CRC_EN to require an XOR checksum word per packet.
//
// state  | meaning
// IDLE   | waiting for a header word, in_ready high
// LOAD   | accepting NumRows data words into FrameData rows
// CHECK  | accepting the checksum word (FRAME_CRC_EN builds only)
// STROBE | one FrameStrobe bit high for StrobeCycles clocks
// GAP    | single low-strobe cycle before returning to IDLE
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic [FrameBitsPerRow-1:0]            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  input  logic                                  err_clr,
  output logic [15:0]                           frames_done
);

  localparam int StrobeW = MaxFramesPerCol * NumColumns;
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int CntW    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  localparam logic [RowW-1:0] LastRow    = RowW'(NumRows - 1);
  localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
  localparam logic [7:0]      NumColsL   = 8'(NumColumns);
  localparam logic [5:0]      NumFramesL = 6'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef FRAME_CRC_EN
    S_CHECK,
`endif
    S_STROBE,
    S_GAP
  } state_t;

  state_t              state;
  logic [7:0]          col_q;
  logic [4:0]          frame_q;
  logic [RowW-1:0]     row_q;
  logic                drop_q;
  logic [CntW-1:0]     strobe_cnt;
  logic [15:0]         strobe_idx;
  logic [StrobeW-1:0]  strobe_onehot;
  logic                accept;
`ifdef FRAME_CRC_EN
  logic [FrameBitsPerRow-1:0] crc_q;
`endif

  assign accept        = in_valid & in_ready;
  assign strobe_idx    = 16'(col_q) * 16'(MaxFramesPerCol) + 16'(frame_q);
  assign strobe_onehot = {{(StrobeW-1){1'b0}}, 1'b1} << strobe_idx;

  // Packet sequencing; every output is a flop so nothing downstream sees glitches.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      frames_done <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      row_q       <= '0;
      drop_q      <= 1'b0;
      strobe_cnt  <= '0;
`ifdef FRAME_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      // Clear first so an error raised later in this same cycle wins.
      if (err_clr) err <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            col_q   <= in_data[15:8];
            frame_q <= in_data[4:0];
            row_q   <= '0;
`ifdef FRAME_CRC_EN
            crc_q   <= '0;
`endif
            if (in_data[31:24] != 8'hFA) begin
              err <= 1'b1;
            end else begin
              state  <= S_LOAD;
              busy   <= 1'b1;
              drop_q <= (in_data[15:8] >= NumColsL) ||
                        ({1'b0, in_data[4:0]} >= NumFramesL);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (!drop_q) FrameData[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
`ifdef FRAME_CRC_EN
            crc_q <= crc_q ^ in_data;
`endif
            row_q <= row_q + 1'b1;
            if (row_q == LastRow) begin
              if (drop_q) err <= 1'b1;
`ifdef FRAME_CRC_EN
              state <= S_CHECK;
`else
              in_ready <= 1'b0;
              if (drop_q) begin
                state <= S_GAP;
              end else begin
                state       <= S_STROBE;
                FrameStrobe <= strobe_onehot;
                strobe_cnt  <= StrobeLoad;
                frames_done <= frames_done + 16'd1;
              end
`endif
            end
          end
        end
`ifdef FRAME_CRC_EN
        S_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (drop_q) begin
              state <= S_GAP;
            end else if (in_data != crc_q) begin
              err   <= 1'b1;
              state <= S_GAP;
            end else begin
              state       <= S_STROBE;
              FrameStrobe <= strobe_onehot;
              strobe_cnt  <= StrobeLoad;
              frames_done <= frames_done + 16'd1;
            end
          end
        end
`endif
        S_STROBE: begin
          if (strobe_cnt == '0) begin
            FrameStrobe <= '0;
            state       <= S_GAP;
          end else begin
            strobe_cnt <= strobe_cnt - 1'b1;
          end
        end
        S_GAP: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          in_ready    <= 1'b0;
          FrameStrobe <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: directed packets followed by random
// packets, checked against a packet-level model of the expected outcome.
`timescale 1ns/1ps
module tb_frame_strobe_sequencer;

  localparam int MaxFramesPerCol = 20;
  localparam int FrameBitsPerRow = 32;
  localparam int NumRows         = 4;
  localparam int NumColumns      = 4;
  localparam int StrobeCycles    = 2;
`ifdef FRAME_CRC_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic          UserCLK = 1'b0;
  logic          resetn  = 1'b0;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  FrameData;
  logic [79:0]   FrameStrobe;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [15:0]   frames_done;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_fd;
  logic         exp_err;
  logic [15:0]  exp_done;

  always #5 UserCLK = ~UserCLK;

  frame_strobe_sequencer #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .FrameBitsPerRow(FrameBitsPerRow),
    .NumRows(NumRows),
    .NumColumns(NumColumns),
    .StrobeCycles(StrobeCycles)
  ) dut (
    .UserCLK(UserCLK),
    .resetn(resetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err(err),
    .err_clr(err_clr),
    .frames_done(frames_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xsum(input logic [127:0] w);
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

  task automatic do_reset();
    @(negedge UserCLK);
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_fd", FrameData, 128'd0);
    chk("rst_strobe", {48'd0, FrameStrobe}, 128'd0);
    chk("rst_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_done", {112'd0, frames_done}, 128'd0);
    exp_fd   = '0;
    exp_err  = 1'b0;
    exp_done = '0;
    @(negedge UserCLK);
    resetn = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall_max);
    int gaps;
    int waited;
    gaps   = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    waited = 0;
    for (int i = 0; i < gaps; i++) begin
      @(negedge UserCLK);
      in_valid = 1'b0;
      in_data  = $urandom;
      chk("strobe_quiet", {48'd0, FrameStrobe}, 128'd0);
    end
    @(negedge UserCLK);
    in_valid = 1'b1;
    in_data  = w;
    chk("strobe_quiet", {48'd0, FrameStrobe}, 128'd0);
    while (!in_ready && waited < 20) begin
      @(negedge UserCLK);
      waited++;
    end
    if (!in_ready) chk("ready_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge UserCLK);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic clear_err();
    @(negedge UserCLK);
    err_clr = 1'b1;
    @(negedge UserCLK);
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", {127'd0, err}, 128'd0);
  endtask

  task automatic run_packet(input logic [31:0] hdr, input logic [127:0] words,
                            input logic [31:0] cks, input int stall_max);
    int          col;
    int          fr;
    bit          drop;
    bit          good;
    bit          rdy;
    logic [79:0] exp_sb;
    col    = int'(hdr[15:8]);
    fr     = int'(hdr[4:0]);
    exp_sb = '0;
    send_word(hdr, stall_max);
    if (hdr[31:24] != 8'hFA) begin
      exp_err = 1'b1;
      @(negedge UserCLK);
      chk("badsync_err", {127'd0, err}, {127'd0, exp_err});
      chk("badsync_busy", {127'd0, busy}, 128'd0);
      chk("badsync_ready", {127'd0, in_ready}, 128'd1);
      chk("badsync_strobe", {48'd0, FrameStrobe}, 128'd0);
      return;
    end
    for (int r = 0; r < NumRows; r++) send_word(words[r*32 +: 32], stall_max);
    if (CrcEn) send_word(cks, stall_max);
    drop = (col >= NumColumns) || (fr >= MaxFramesPerCol);
    good = !drop && (!CrcEn || cks == xsum(words));
    if (!drop) exp_fd = words;
    if (!good) exp_err = 1'b1;
    if (good) begin
      exp_done = exp_done + 16'd1;
      exp_sb   = 80'd1 << (col * MaxFramesPerCol + fr);
    end
    for (int k = 1; k <= StrobeCycles + 2; k++) begin
      @(negedge UserCLK);
      chk("strobe", {48'd0, FrameStrobe},
          {48'd0, (good && k <= StrobeCycles) ? exp_sb : 80'd0});
      rdy = good ? (k > StrobeCycles + 1) : (k > 1);
      chk("ready", {127'd0, in_ready}, {127'd0, rdy});
      chk("busy", {127'd0, busy}, {127'd0, !rdy});
      chk("fd", FrameData, exp_fd);
    end
    chk("err", {127'd0, err}, {127'd0, exp_err});
    chk("done", {112'd0, frames_done}, {112'd0, exp_done});
  endtask

  initial begin
    logic [31:0]  hdr;
    logic [127:0] w;
    logic [31:0]  cks;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    exp_fd   = '0;
    exp_err  = 1'b0;
    exp_done = '0;

    do_reset();
    w = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    run_packet(32'hFA00_0103, w, xsum(w), 0);
    chk("tp_framedata", FrameData, 128'h44444444_33333333_22222222_11111111);

    w = {$urandom, $urandom, $urandom, $urandom};
    run_packet(32'hFA00_0500, w, xsum(w), 0);
    clear_err();

    run_packet(32'h1200_0000, w, xsum(w), 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    run_packet(32'hFA00_0000, w, xsum(w), 1);
    clear_err();

    do_reset();
    w = {$urandom, $urandom, $urandom, $urandom};
    run_packet(32'hFA00_0313, w, xsum(w), 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    run_packet(32'hFA00_0300, w, xsum(w), 0);

    send_word(32'hFA00_0201, 0);
    send_word($urandom, 0);
    send_word($urandom, 0);
    do_reset();
    w = {$urandom, $urandom, $urandom, $urandom};
    run_packet(32'hFA00_0201, w, xsum(w), 1);

    @(negedge UserCLK);
    chk("pre_same_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = 32'h1200_0000;
    err_clr  = 1'b1;
    @(negedge UserCLK);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    exp_err  = 1'b1;
    chk("err_set_wins", {127'd0, err}, 128'd1);
    clear_err();

`ifdef FRAME_CRC_EN
    w = {32'h8, 32'h4, 32'h2, 32'h1};
    run_packet(32'hFA00_0102, w, 32'h0000_000F, 0);
    run_packet(32'hFA00_0104, w, 32'h0000_000E, 0);
    clear_err();
`endif

    for (int n = 0; n < 60; n++) begin
      hdr = $urandom;
      hdr[31:24] = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'hFA;
      hdr[15:8]  = 8'($urandom_range(5, 0));
      hdr[4:0]   = 5'($urandom_range(23, 0));
      w   = {$urandom, $urandom, $urandom, $urandom};
      cks = xsum(w);
      if ($urandom_range(3, 0) == 0) cks = cks ^ (32'd1 << $urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) clear_err();
      run_packet(hdr, w, cks, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
